smem_fill_ctrl: RTL and testbench

// - Sequencer and arbiter for the screen-memory (smem) write port.
// - Shares the port between CPU stores (address window cpu_addr[17:16]==2'b10) and a rectangle-fill engine.
// - The fill engine writes one character code into every cell of a rectangle on the 40x30 tile screen (clear, HUD boxes).
// - Sits between the CPU bus and the dual-port smem; the CPU always wins the port and the engine stalls.

---
 rtl/smem_fill_ctrl_if.sv | 40 ++++
 rtl/smem_fill_ctrl.sv | 125 ++++++++++++
 tb/tb_smem_fill_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/smem_fill_ctrl_if.sv
// Bus bundle for smem_fill_ctrl: CPU store port, fill request and smem write port.
// Build option SMEM_FILL_ABORT_EN adds the abort request line.
interface smem_fill_ctrl_if #(
    parameter int unsigned CHAR_BITS = 2,
    parameter int unsigned ADDR_BITS = 11
);
    logic                 cpu_wr;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_writedata;
    logic                 start;
    logic [CHAR_BITS-1:0] fill_char;
    logic [5:0]           x0;
    logic [5:0]           x1;
    logic [4:0]           y0;
    logic [4:0]           y1;
`ifdef SMEM_FILL_ABORT_EN
    logic                 abort;
`endif
    logic                 busy;
    logic                 done;
    logic                 smem_wr;
    logic [ADDR_BITS-1:0] smem_addr;
    logic [CHAR_BITS-1:0] smem_wdata;

    modport master (
        output cpu_wr, cpu_addr, cpu_writedata, start, fill_char, x0, x1, y0, y1,
`ifdef SMEM_FILL_ABORT_EN
        output abort,
`endif
        input  busy, done, smem_wr, smem_addr, smem_wdata
    );

    modport slave (
        input  cpu_wr, cpu_addr, cpu_writedata, start, fill_char, x0, x1, y0, y1,
`ifdef SMEM_FILL_ABORT_EN
        input  abort,
`endif
        output busy, done, smem_wr, smem_addr, smem_wdata
    );
endinterface

// File: rtl/smem_fill_ctrl.sv
// Screen-memory write-port arbiter: CPU stores always win, rectangle-fill engine stalls.
// Build option SMEM_FILL_ABORT_EN enables abort of a running fill.
module smem_fill_ctrl #(
    parameter int unsigned COLS      = 40,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned CHAR_BITS = 2,
    parameter int unsigned ADDR_BITS = $clog2(COLS * ROWS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    smem_fill_ctrl_if.slave      io_bus
);
    localparam int unsigned XW = 6;
    localparam int unsigned YW = 5;
    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
    localparam logic [31:0]   COLS_V = COLS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [XW-1:0]        r_x;
    logic [XW-1:0]        r_x0;
    logic [XW-1:0]        r_x1;
    logic [YW-1:0]        r_y;
    logic [YW-1:0]        r_y1;
    logic [ADDR_BITS-1:0] r_row_base;
    logic [CHAR_BITS-1:0] r_char;

    logic                 w_cpu_sel;
    logic                 w_abort;
    logic                 w_eng_wr;
    logic                 w_last;
    logic                 w_empty;
    logic [XW-1:0]        w_x1c;
    logic [YW-1:0]        w_y1c;
    logic [ADDR_BITS-1:0] w_row_base0;
    logic                 w_unused;

    // Constant multiply by COLS as a sum of shifted copies of y.
    function automatic logic [ADDR_BITS-1:0] mul_cols(input logic [YW-1:0] y);
        logic [ADDR_BITS-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (COLS_V[i]) acc = acc + (ADDR_BITS'(y) << i);
        end
        return acc;
    endfunction

    assign w_cpu_sel   = io_bus.cpu_wr && (io_bus.cpu_addr[17:16] == 2'b10);
`ifdef SMEM_FILL_ABORT_EN
    assign w_abort     = io_bus.abort;
`else
    assign w_abort     = 1'b0;
`endif
    assign w_eng_wr    = (r_state == S_FILL) && !w_cpu_sel && !w_abort;
    assign w_last      = (r_x == r_x1) && (r_y == r_y1);
    assign w_x1c       = (io_bus.x1 > X_MAX) ? X_MAX : io_bus.x1;
    assign w_y1c       = (io_bus.y1 > Y_MAX) ? Y_MAX : io_bus.y1;
    assign w_empty     = (io_bus.x0 > w_x1c) || (io_bus.y0 > w_y1c);
    assign w_row_base0 = mul_cols(io_bus.y0);
    assign w_unused    = ^{io_bus.cpu_addr[31:18], io_bus.cpu_addr[15:ADDR_BITS+2],
                           io_bus.cpu_addr[1:0], io_bus.cpu_writedata[31:CHAR_BITS]};

    assign io_bus.busy = (r_state == S_FILL) || (r_state == S_DONE);
    assign io_bus.done = (r_state == S_DONE);

    always_comb begin
        io_bus.smem_wr    = w_eng_wr;
        io_bus.smem_addr  = r_row_base + ADDR_BITS'(r_x);
        io_bus.smem_wdata = r_char;
        if (w_cpu_sel) begin
            io_bus.smem_wr    = 1'b1;
            io_bus.smem_addr  = io_bus.cpu_addr[ADDR_BITS+1:2];
            io_bus.smem_wdata = io_bus.cpu_writedata[CHAR_BITS-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_x0       <= '0;
            r_x1       <= '0;
            r_y        <= '0;
            r_y1       <= '0;
            r_row_base <= '0;
            r_char     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_x0       <= io_bus.x0;
                        r_x1       <= w_x1c;
                        r_y1       <= w_y1c;
                        r_x        <= io_bus.x0;
                        r_y        <= io_bus.y0;
                        r_row_base <= w_row_base0;
                        r_char     <= io_bus.fill_char;
                        r_state    <= w_empty ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_eng_wr) begin
                        // A stalled cycle leaves (x,y) untouched, so a CPU hit is re-filled.
                        if (r_x < r_x1) begin
                            r_x <= r_x + 1'b1;
                        end else begin
                            r_x        <= r_x0;
                            r_y        <= r_y + 1'b1;
                            r_row_base <= r_row_base + ADDR_BITS'(COLS);
                        end
                        if (w_last) r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smem_fill_ctrl.sv
// Self-checking bench for smem_fill_ctrl: table of fill rectangles plus hand-written corner cases.
// Abort sequence is built only with SMEM_FILL_ABORT_EN.
module tb_smem_fill_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   done_cnt;
    int   wr_cnt;
    int   acc_cyc;

    typedef struct packed {
        logic [10:0] addr;
        logic [1:0]  data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [5:0] x0;
        logic [5:0] x1;
        logic [4:0] y0;
        logic [4:0] y1;
        logic [1:0] ch;
        int         exp_wr;
        int         exp_lat;
    } vec_t;
    vec_t vecs[7];

    smem_fill_ctrl_if #(.CHAR_BITS(2), .ADDR_BITS(11)) bus ();

    smem_fill_ctrl #(
        .COLS(40), .ROWS(30), .CHAR_BITS(2), .ADDR_BITS(11)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write scoreboard: every smem write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (bus.done) done_cnt++;
        if (bus.smem_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0d, want no write",
                         bus.smem_addr, bus.smem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", int'(bus.smem_addr), int'(e.addr));
                chk("write_data", int'(bus.smem_wdata), int'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int addr, input logic [1:0] data);
        wr_t e;
        e.addr = 11'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                             input logic [1:0] ch);
        int xe;
        int ye;
        xe = (x1 > 39) ? 39 : x1;
        ye = (y1 > 29) ? 29 : y1;
        for (int y = y0; y <= ye; y++)
            for (int x = x0; x <= xe; x++)
                push_wr(y * 40 + x, ch);
    endtask

    // Called at posedge+1 with the DUT idle; returns in the first cycle after accept.
    task automatic start_fill(input logic [5:0] x0, input logic [5:0] x1, input logic [4:0] y0,
                              input logic [4:0] y1, input logic [1:0] ch);
        bus.x0 = x0;
        bus.x1 = x1;
        bus.y0 = y0;
        bus.y1 = y1;
        bus.fill_char = ch;
        bus.start = 1'b1;
        acc_cyc = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int got;
        int lat;
        got = 0;
        lat = -1;
        for (int i = 0; i < 1500 && got == 0; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                lat = cyc - acc_cyc;
            end else begin
                tick();
            end
        end
        chk({name, "_done_seen"}, got, 1);
        chk({name, "_latency"}, lat, exp_lat);
        tick();
    endtask

    initial begin
        int d0;
        int w0;
        cyc = 0; total = 0; bad = 0; done_cnt = 0; wr_cnt = 0; acc_cyc = 0;
        rst_n = 1'b0;
        bus.cpu_wr = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_writedata = '0;
        bus.start = 1'b0;
        bus.fill_char = '0;
        bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
`ifdef SMEM_FILL_ABORT_EN
        bus.abort = 1'b0;
`endif
        vecs[0] = '{x0: 6'd0,  x1: 6'd39, y0: 5'd0,  y1: 5'd29, ch: 2'd0, exp_wr: 1200, exp_lat: 1201};
        vecs[1] = '{x0: 6'd5,  x1: 6'd7,  y0: 5'd2,  y1: 5'd3,  ch: 2'd3, exp_wr: 6,    exp_lat: 7};
        vecs[2] = '{x0: 6'd10, x1: 6'd4,  y0: 5'd0,  y1: 5'd0,  ch: 2'd1, exp_wr: 0,    exp_lat: 1};
        vecs[3] = '{x0: 6'd38, x1: 6'd63, y0: 5'd29, y1: 5'd31, ch: 2'd1, exp_wr: 2,    exp_lat: 3};
        vecs[4] = '{x0: 6'd0,  x1: 6'd0,  y0: 5'd0,  y1: 5'd0,  ch: 2'd2, exp_wr: 1,    exp_lat: 2};
        vecs[5] = '{x0: 6'd0,  x1: 6'd3,  y0: 5'd30, y1: 5'd31, ch: 2'd2, exp_wr: 0,    exp_lat: 1};
        vecs[6] = '{x0: 6'd39, x1: 6'd39, y0: 5'd0,  y1: 5'd29, ch: 2'd1, exp_wr: 30,   exp_lat: 31};

        repeat (2) tick();
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_smem_wr", int'(bus.smem_wr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", int'(bus.busy), 0);

        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            w0 = wr_cnt;
            push_rect(int'(vecs[i].x0), int'(vecs[i].x1), int'(vecs[i].y0), int'(vecs[i].y1),
                      vecs[i].ch);
            start_fill(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].ch);
            chk($sformatf("vec%0d_busy", i), int'(bus.busy), 1);
            wait_done($sformatf("vec%0d", i), vecs[i].exp_lat);
            chk($sformatf("vec%0d_writes", i), wr_cnt - w0, vecs[i].exp_wr);
            chk($sformatf("vec%0d_pending", i), exp_q.size(), 0);
            chk($sformatf("vec%0d_done_pulses", i), done_cnt - d0, 1);
            chk($sformatf("vec%0d_idle_done", i), int'(bus.done), 0);
            chk($sformatf("vec%0d_idle_busy", i), int'(bus.busy), 0);
        end

        // CPU contention: stores to index 100 in FILL cycles 2 and 3, an off-window store in 4.
        d0 = done_cnt;
        w0 = wr_cnt;
        push_wr(85, 2'd3);
        push_wr(100, 2'd1);
        push_wr(100, 2'd1);
        push_wr(86, 2'd3);
        push_wr(87, 2'd3);
        push_wr(125, 2'd3);
        push_wr(126, 2'd3);
        push_wr(127, 2'd3);
        start_fill(6'd5, 6'd7, 5'd2, 5'd3, 2'd3);
        tick();
        bus.cpu_wr = 1'b1;
        bus.cpu_addr = 32'h0002_0000 + 32'd400;
        bus.cpu_writedata = 32'hFFFF_FFF5;
        tick();
        tick();
        bus.cpu_addr = 32'h0001_0000 + 32'd400;
        tick();
        bus.cpu_wr = 1'b0;
        wait_done("contend", 9);
        chk("contend_writes", wr_cnt - w0, 8);
        chk("contend_pending", exp_q.size(), 0);
        chk("contend_done_pulses", done_cnt - d0, 1);

        // A start held through the DONE cycle must not launch a new fill.
        w0 = wr_cnt;
        start_fill(6'd10, 6'd4, 5'd0, 5'd0, 2'd1);
        bus.x0 = 6'd0; bus.x1 = 6'd1; bus.y0 = 5'd0; bus.y1 = 5'd0;
        bus.start = 1'b1;
        @(negedge clk);
        chk("done_start_done", int'(bus.done), 1);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", int'(bus.busy), 0);
        tick();
        chk("done_start_writes", wr_cnt - w0, 0);

        // Second start while busy is ignored; reset in FILL cycle 11 aborts with no done.
        d0 = done_cnt;
        for (int a = 0; a < 10; a++) push_wr(a, 2'd2);
        start_fill(6'd0, 6'd39, 5'd0, 5'd29, 2'd2);
        tick();
        tick();
        bus.x0 = 6'd5; bus.x1 = 6'd7; bus.y0 = 5'd2; bus.y1 = 5'd3; bus.fill_char = 2'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_smem_wr", int'(bus.smem_wr), 0);
        chk("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_pending", exp_q.size(), 0);
        chk("rst_no_done", done_cnt - d0, 0);
        push_rect(5, 7, 2, 3, 2'd3);
        start_fill(6'd5, 6'd7, 5'd2, 5'd3, 2'd3);
        wait_done("after_rst", 7);
        chk("after_rst_pending", exp_q.size(), 0);

`ifdef SMEM_FILL_ABORT_EN
        d0 = done_cnt;
        w0 = wr_cnt;
        push_wr(0, 2'd1);
        push_wr(1, 2'd1);
        push_wr(2, 2'd1);
        start_fill(6'd0, 6'd39, 5'd0, 5'd29, 2'd1);
        repeat (3) tick();
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_no_write", int'(bus.smem_wr), 0);
        tick();
        bus.abort = 1'b0;
        chk("abort_idle", int'(bus.busy), 0);
        repeat (3) tick();
        chk("abort_writes", wr_cnt - w0, 3);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_pending", exp_q.size(), 0);
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by cycle %0d, want finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
